// File: rtl/adder_pkg.sv
// Shared types for the adder result path: operand width and the stored result word.
package adder_pkg;

  localparam int ADD_W = 8;

  typedef struct packed {
    logic             carry;
    logic [ADD_W-1:0] sum;
  } add_result_t;

endpackage

// File: rtl/adder_result_mem.sv
// DEPTH-entry register array of adder results: one write port, one async read port,
// asynchronous clear so no stale entry is visible after reset.
module adder_result_mem
  import adder_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  add_result_t   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output add_result_t   rdata_o
);

  add_result_t mem_q [DEPTH];

  // Storage write; every entry cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/adder_result_buf.sv
// Capture stage for the 8-bit adder: samples {carry,sum} on in_valid, buffers them
// in a show-ahead FIFO for a valid/ready consumer, and keeps saturating counts of
// carry-out results and of results dropped because the buffer was full.
module adder_result_buf
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_carry,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic [CNT_W-1:0] carry_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             push, pop;
  add_result_t      wr_word, rd_word;

  // Handshake flags come only from the registered count, so there is no in->out path.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign wr_word.carry = in_carry;
  assign wr_word.sum   = in_sum;

  adder_result_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_word),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_word)
  );

  assign out_sum   = rd_word.sum;
  assign out_carry = rd_word.carry;
  assign count     = count_q;
  assign carry_cnt = carry_cnt_q;
  assign drop_cnt  = drop_cnt_q;

  // Next-state for pointers, occupancy and the saturating statistics counters.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    carry_cnt_d = carry_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (in_carry) begin
        carry_cnt_d = sat_inc(carry_cnt_q);
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (in_valid && !in_ready) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers; asynchronous clear discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      carry_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      carry_cnt_q <= carry_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_adder_result_buf.sv
// Directed bench for adder_result_buf with hand-computed expectations.
module tb_adder_result_buf;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_sum;
  logic       in_carry;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_sum;
  logic       out_carry;
  logic       out_ready;
  logic [2:0] count;
  logic [7:0] carry_cnt;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  adder_result_buf #(.WIDTH(8), .DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ready (out_ready),
    .count     (count),
    .carry_cnt (carry_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_sum    = 8'h00;
    in_carry  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    checks++; if ({out_carry, out_sum} !== 9'h000) begin errors++; $display("FAIL rst_out_data got %h exp 000", {out_carry, out_sum}); end
    // Mid-run reset with three entries buffered, including a carry and a drop-free state.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_sum = 8'h30 + 8'(i); in_carry = 1'b1;
      step();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL pre_rst_count got %0d exp 3", count); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL async_rst_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL async_rst_flags got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
    checks++; if (carry_cnt !== 8'd0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL async_rst_cnts got c=%0d d=%0d exp 0 0", carry_cnt, drop_cnt); end
    checks++; if ({out_carry, out_sum} !== 9'h000) begin errors++; $display("FAIL async_rst_data got %h exp 000", {out_carry, out_sum}); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1'b1; in_sum = 8'h0F; in_carry = 1'b0;  // 5 + 10
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL single_valid got v=%b c=%0d exp v=1 c=1", out_valid, count); end
    checks++; if ({out_carry, out_sum} !== 9'h00F) begin errors++; $display("FAIL single_data got %h exp 00F", {out_carry, out_sum}); end
    step();
    checks++; if ({out_carry, out_sum} !== 9'h00F || count !== 3'd1) begin errors++; $display("FAIL single_hold got %h c=%0d exp 00F c=1", {out_carry, out_sum}, count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_pop got c=%0d v=%b exp c=0 v=0", count, out_valid); end
    // Push into an empty buffer while out_ready is high: the new entry must not pop.
    in_valid = 1'b1; in_sum = 8'h55; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd1 || out_sum !== 8'h55) begin errors++; $display("FAIL empty_push_pop got c=%0d s=%h exp c=1 s=55", count, out_sum); end
  endtask

  task automatic test_carry();
    do_reset();
    in_valid = 1'b1; in_sum = 8'h00; in_carry = 1'b1;  // FF + 01
    step();
    in_valid = 1'b0; in_carry = 1'b0;
    checks++; if (out_sum !== 8'h00 || out_carry !== 1'b1) begin errors++; $display("FAIL carry_data got %b/%h exp 1/00", out_carry, out_sum); end
    checks++; if (carry_cnt !== 8'd1) begin errors++; $display("FAIL carry_cnt got %0d exp 1", carry_cnt); end
  endtask

  task automatic test_fill();
    do_reset();
    in_valid = 1'b1; in_carry = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_sum = 8'(i);
      step();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL fill_full got c=%0d r=%b exp c=4 r=0", count, in_ready); end
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL fill_drop got %0d exp 2", drop_cnt); end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_sum !== 8'(i)) begin errors++; $display("FAIL fill_order got v=%b s=%h exp v=1 s=%h", out_valid, out_sum, 8'(i)); end
      step();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL fill_extra got v=%b c=%0d exp v=0 c=0", out_valid, count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1; in_carry = 1'b0;
    in_sum = 8'h10; step();
    in_sum = 8'h11; step();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_sum = 8'h12 + 8'(i);
      checks++; if (out_sum !== 8'h10 + 8'(i)) begin errors++; $display("FAIL stream_order got %h exp %h", out_sum, 8'h10 + 8'(i)); end
      step();
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL stream_count got %0d exp 2", count); end
    end
    // Full with a simultaneous pop: input dropped, occupancy 4 -> 3.
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sum = 8'hA0 + 8'(i);
      step();
    end
    in_sum = 8'hAA; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd3 || drop_cnt !== 8'd1) begin errors++; $display("FAIL fullpop got c=%0d d=%0d exp c=3 d=1", count, drop_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_ready got %b exp 1", in_ready); end
    for (int i = 1; i <= 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_sum !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL fullpop_order got v=%b s=%h exp v=1 s=%h", out_valid, out_sum, 8'hA0 + 8'(i)); end
      step();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fullpop_absent got v=%b s=%h exp v=0", out_valid, out_sum); end
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid = 1'b1; in_carry = 1'b1; in_sum = 8'h77; out_ready = 1'b1;
    for (int i = 0; i < 254; i++) step();
    checks++; if (carry_cnt !== 8'hFE) begin errors++; $display("FAIL carry_sat_pre got %h exp FE", carry_cnt); end
    for (int i = 0; i < 46; i++) step();
    checks++; if (carry_cnt !== 8'hFF) begin errors++; $display("FAIL carry_sat got %h exp FF", carry_cnt); end
    checks++; if (count !== 3'd1 || drop_cnt !== 8'd0) begin errors++; $display("FAIL carry_sat_flow got c=%0d d=%0d exp c=1 d=0", count, drop_cnt); end
    do_reset();
    in_valid = 1'b1; in_carry = 1'b0;
    for (int i = 0; i < 4 + 254; i++) step();
    checks++; if (drop_cnt !== 8'hFE) begin errors++; $display("FAIL drop_sat_pre got %h exp FE", drop_cnt); end
    for (int i = 0; i < 10; i++) step();
    in_valid = 1'b0;
    checks++; if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL drop_sat got %h exp FF", drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_fill();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
